mc_ctrl_fsm: RTL
================

# mc_ctrl_fsm

Multicycle main controller for the MIPS core: a Moore/Mealy FSM that sequences fetch, decode, execute, memory and write-back. It drives every datapath enable and mux select. It extends the existing 5-instruction controller with bne, addi/andi/slti, jal and jr, plus a memory ready handshake. It folds in the PC write-enable logic and a configurable illegal-opcode policy. It sits between the IR outputs of the datapath and the datapath control inputs, replacing the current controller, ALU-op encoder and PC-enable OR gate.

## Interface
- OPW, 6, opcode width
- FNW, 6, funct width
- ILLEGAL_TRAP, 1, 1: illegal opcode enters HALT until reset; 0: treated as NOP and returns to FETCH
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- opcode  in  OPW  IR[31:26]
- funct  in  FNW  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write_en  out  1  PC load enable (unconditional or branch-resolved)
- iord, mem_read, mem_write, ir_write, reg_write, alu_src_a  out  1 each
- alu_op  out  3  000 add, 001 sub, 010 funct-decode, 011 and, 100 slt
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 reg A
- state  out  4  current state (debug)
- halted  out  1  high in HALT

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, andi 001100, slti 001010, j 000010, jal 000011. jr is R-type with funct 001000.
- Unlisted outputs are 0 in each state.
- FETCH: mem_read, src_a 0, src_b 01, add, pc_src 00. On mem_ready: ir_write=1 and pc_write_en=1, go to DECODE. Otherwise stay.
- DECODE: src_a 0, src_b 11, add (branch target into ALUOut). Dispatch:
  - lw/sw → MEM_ADR
  - R with jr funct → JR; other R → R_EXE
  - beq/bne → BRANCH
  - addi/andi/slti → I_EXE
  - j → JUMP; jal → JAL
  - other → HALT (ILLEGAL_TRAP=1) or FETCH (ILLEGAL_TRAP=0)
- MEM_ADR: src_a 1, src_b 10, add → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read, iord 1. On mem_ready → MEM_WB.
- MEM_WB: reg_write, reg_dst 00, m2r 01 → FETCH.
- MEM_WR: mem_write, iord 1. On mem_ready → FETCH.
- R_EXE: src_a 1, src_b 00, alu_op 010 → R_WB.
- R_WB: reg_write, reg_dst 01, m2r 00 → FETCH.
- I_EXE: src_a 1, src_b 10, alu_op 000/011/100 for addi/andi/slti → I_WB. andi uses the sign-extended immediate.
- I_WB: reg_write, reg_dst 00, m2r 00 → FETCH.
- BRANCH: src_a 1, src_b 00, sub, pc_src 01. pc_write_en = zero for beq, ~zero for bne. → FETCH.
- JUMP: pc_src 10, pc_write_en → FETCH.
- JAL: reg_write, reg_dst 10, m2r 10 (PC already holds PC+4), pc_src 10, pc_write_en → FETCH.
- JR: src_a 1, pc_src 11, pc_write_en → FETCH.
- HALT: all enables 0, halted=1. Leaves only on rst.

## Timing
- rst high at a clock edge: state ← FETCH.
- While rst is high, all enable outputs and halted are forced to 0 and selects are 0, regardless of state. The first FETCH cycle is the first cycle with rst low.
- Reset mid-instruction or mid-wait aborts the instruction with no partial writes beyond cycles already completed.
- Outputs are combinational from state. Exceptions:
  - ir_write and the FETCH pc_write_en are qualified by mem_ready.
  - BRANCH pc_write_en is qualified by zero.
- Cycles with zero wait: R/addi/andi/slti 4, lw 5, sw 4, beq/bne/j/jal/jr 3.
- Each memory state adds one cycle per cycle mem_ready is low. mem_read/mem_write and iord stay asserted and stable throughout the wait.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.

## Configuration
- MC_MEM_WAIT_EN defined: mem_ready is honoured as above.
- MC_MEM_WAIT_EN undefined: mem_ready is ignored and treated as 1. Every memory state lasts exactly one cycle, matching single-cycle-memory datapaths.

## Structure
- Package mc_pkg holds:
  - state enum (4-bit)
  - opcode and jr-funct constants
  - alu_op, alu_src_b, reg_dst, mem_to_reg and pc_src encodings
- One sub-module, mc_ctrl_decode: purely combinational state→control-word decoder. The top holds the state register and next-state logic.

## Test plan
- rst held 3 cycles, mem_ready=1, then opcode 000000 funct 100000 → states FETCH, DECODE, R_EXE, R_WB; reg_write=1 with reg_dst 01 only in cycle 4; pc_write_en only in cycle 1.
- lw with mem_ready low 2 cycles in FETCH and 1 cycle in MEM_RD → 8 cycles total; ir_write pulses once, coincident with mem_ready.
- beq with zero=1 and bne with zero=1 → pc_write_en=1 with pc_src 01 for beq; pc_write_en=0 for bne.
- jal → 3 cycles; JAL cycle shows reg_write=1, reg_dst 10, m2r 10, pc_src 10, pc_write_en=1. jr (funct 001000) → pc_src 11.
- opcode 111111 with ILLEGAL_TRAP=1 → HALT, halted=1, all enables 0 for 10 cycles, then rst → FETCH. With ILLEGAL_TRAP=0 → back to FETCH after 2 cycles.
- rst asserted during a MEM_WR wait → next state FETCH, mem_write=0 while rst is high.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS controller: state enum,
// opcode/funct constants, datapath select encodings and the control word.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_R_EXE   = 4'd6,
    S_R_WB    = 4'd7,
    S_I_EXE   = 4'd8,
    S_I_WB    = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_JAL     = 4'd12,
    S_JR      = 4'd13,
    S_HALT    = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b100;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  typedef struct packed {
    logic       pc_write_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [2:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_src;
    logic       halted;
  } ctrl_t;

  // andi uses the sign-extended immediate, so only the ALU function differs
  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: imm_alu_op = ALU_AND;
      OP_SLTI: imm_alu_op = ALU_SLT;
      default: imm_alu_op = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control-word decoder for the multicycle controller.
// Only ir_write/FETCH PC load (mem_ok) and the BRANCH PC load (zero) are Mealy terms.
module mc_ctrl_decode
  import mc_pkg::*;
#(
  parameter int OPW = 6
) (
  input  state_t         state,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ok,
  output ctrl_t          ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read    = 1'b1;
        ctrl.alu_src_b   = SRCB_FOUR;
        ctrl.alu_op      = ALU_ADD;
        ctrl.pc_src      = PCSRC_ALU;
        ctrl.ir_write    = mem_ok;
        ctrl.pc_write_en = mem_ok;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH;
      end
      S_MEM_ADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RDST_RT;
        ctrl.mem_to_reg = M2R_MDR;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_R_EXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = RDST_RD;
      end
      S_I_EXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = imm_alu_op(6'(opcode));
      end
      S_I_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = RDST_RT;
      end
      S_BRANCH: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src_b   = SRCB_B;
        ctrl.alu_op      = ALU_SUB;
        ctrl.pc_src      = PCSRC_ALUOUT;
        ctrl.pc_write_en = (opcode == OPW'(OP_BNE)) ? ~zero : zero;
      end
      S_JUMP: begin
        ctrl.pc_src      = PCSRC_JUMP;
        ctrl.pc_write_en = 1'b1;
      end
      S_JAL: begin
        ctrl.reg_write   = 1'b1;
        ctrl.reg_dst     = RDST_RA;
        ctrl.mem_to_reg  = M2R_PC;
        ctrl.pc_src      = PCSRC_JUMP;
        ctrl.pc_write_en = 1'b1;
      end
      S_JR: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.pc_src      = PCSRC_REGA;
        ctrl.pc_write_en = 1'b1;
      end
      S_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main controller: state register, next-state dispatch and reset gating.
// Define MC_MEM_WAIT_EN to honour mem_ready; otherwise every memory access completes in one cycle.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int OPW          = 6,
  parameter int FNW          = 6,
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic [FNW-1:0] funct,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           pc_write_en,
  output logic           iord,
  output logic           mem_read,
  output logic           mem_write,
  output logic           ir_write,
  output logic           reg_write,
  output logic           alu_src_a,
  output logic [2:0]     alu_op,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     reg_dst,
  output logic [1:0]     mem_to_reg,
  output logic [1:0]     pc_src,
  output logic [3:0]     state,
  output logic           halted
);

  state_t state_reg, state_next;
  ctrl_t  ctrl, ctrl_out;
  logic   mem_ok;

`ifdef MC_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok           = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_FETCH;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:  if (mem_ok) state_next = S_DECODE;
      S_DECODE: begin
        if (opcode == OPW'(OP_LW) || opcode == OPW'(OP_SW))
          state_next = S_MEM_ADR;
        else if (opcode == OPW'(OP_RTYPE))
          state_next = (funct == FNW'(FN_JR)) ? S_JR : S_R_EXE;
        else if (opcode == OPW'(OP_BEQ) || opcode == OPW'(OP_BNE))
          state_next = S_BRANCH;
        else if (opcode == OPW'(OP_ADDI) || opcode == OPW'(OP_ANDI) ||
                 opcode == OPW'(OP_SLTI))
          state_next = S_I_EXE;
        else if (opcode == OPW'(OP_J))
          state_next = S_JUMP;
        else if (opcode == OPW'(OP_JAL))
          state_next = S_JAL;
        else
          state_next = (ILLEGAL_TRAP != 0) ? S_HALT : S_FETCH;
      end
      S_MEM_ADR: state_next = (opcode == OPW'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  if (mem_ok) state_next = S_MEM_WB;
      S_MEM_WR:  if (mem_ok) state_next = S_FETCH;
      S_R_EXE:   state_next = S_R_WB;
      S_I_EXE:   state_next = S_I_WB;
      S_HALT:    state_next = S_HALT;
      default:   state_next = S_FETCH;
    endcase
  end

  mc_ctrl_decode #(
    .OPW(OPW)
  ) u_decode (
    .state  (state_reg),
    .opcode (opcode),
    .zero   (zero),
    .mem_ok (mem_ok),
    .ctrl   (ctrl)
  );

  // Reset overrides whatever the state register still holds, so no write leaks out
  assign ctrl_out = rst ? '0 : ctrl;

  assign pc_write_en = ctrl_out.pc_write_en;
  assign iord        = ctrl_out.iord;
  assign mem_read    = ctrl_out.mem_read;
  assign mem_write   = ctrl_out.mem_write;
  assign ir_write    = ctrl_out.ir_write;
  assign reg_write   = ctrl_out.reg_write;
  assign alu_src_a   = ctrl_out.alu_src_a;
  assign alu_op      = ctrl_out.alu_op;
  assign alu_src_b   = ctrl_out.alu_src_b;
  assign reg_dst     = ctrl_out.reg_dst;
  assign mem_to_reg  = ctrl_out.mem_to_reg;
  assign pc_src      = ctrl_out.pc_src;
  assign halted      = ctrl_out.halted;
  assign state       = state_reg;

endmodule
